// File: rtl/aquaflex_pkg.sv
// AquaFlex flow sequencer shared definitions: FSM states,
// inlet/outlet codes, switch port indices, valve phase table, status codes.
package aquaflex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_IN,
    ST_PUMP_IN,
    ST_MIX,
    ST_SET_OUT,
    ST_PUMP_OUT,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ILLEGAL = 2'd1,
    STAT_ABORTED = 2'd2
  } status_e;

  localparam logic [2:0] SRC_B = 3'd0;
  localparam logic [2:0] SRC_C = 3'd1;
  localparam logic [2:0] SRC_D = 3'd2;
  localparam logic [2:0] SRC_E = 3'd3;
  localparam logic [2:0] SRC_F = 3'd4;

  localparam logic [1:0] DST_H = 2'd0;
  localparam logic [1:0] DST_I = 2'd1;
  localparam logic [1:0] DST_J = 2'd2;

  localparam logic [1:0] SW1_PORT_B   = 2'd3;
  localparam logic [1:0] SW1_PORT_F   = 2'd0;
  localparam logic [1:0] SW1_PORT_SW0 = 2'd1;
  localparam logic [1:0] SW0_PORT_C   = 2'd2;
  localparam logic [1:0] SW0_PORT_D   = 2'd0;
  localparam logic [1:0] SW0_PORT_E   = 2'd3;
  localparam logic [1:0] SW2_PORT_H   = 2'd2;
  localparam logic [1:0] SW2_PORT_I   = 2'd3;
  localparam logic [1:0] SW2_PORT_J   = 2'd1;

  localparam int unsigned N_PHASE = 6;

  // Entry 0 is the first phase of a stroke.
  localparam logic [5:0][2:0] PHASE_TBL = {
    3'b101, 3'b001, 3'b011,
    3'b010, 3'b110, 3'b100
  };

  function automatic logic cmd_legal(
    input logic [2:0] src,
    input logic [1:0] dst
  );
    return (src <= SRC_F) && (dst <= DST_J);
  endfunction

endpackage

// File: rtl/aquaflex_flow_sequencer_pump.sv
// Peristaltic pump driver: start/strokes load a run, stop kills it.
// valve = registered 3-valve pattern; busy = more pump cycles follow this one.
module peristaltic_pump_drv
  import aquaflex_pkg::*;
#(
  parameter int PHASE_CYC = 2,
  parameter int STROKE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [STROKE_W-1:0] strokes,
  input  logic                stop,
  output logic [2:0]          valve,
  output logic                busy
);

  localparam int PCW =
    (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [PCW-1:0] PC_LAST =
    PCW'(PHASE_CYC - 1);
  localparam logic [2:0] PH_LAST =
    3'(N_PHASE - 1);

  logic                active_q, active_d;
  logic [2:0]          phase_q, phase_d;
  logic [PCW-1:0]      pcnt_q, pcnt_d;
  logic [STROKE_W-1:0] left_q, left_d;
  logic [2:0]          valve_q, valve_d;
  logic                phase_end;
  logic                stroke_end;
  logic                last;

  assign phase_end  = active_q && (pcnt_q == PC_LAST);
  assign stroke_end = phase_end && (phase_q == PH_LAST);
  assign last = stroke_end && (left_q <= STROKE_W'(1));

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    pcnt_d   = pcnt_q;
    left_d   = left_q;
    valve_d  = valve_q;
    if (stop || last) begin
      active_d = 1'b0;
      phase_d  = '0;
      pcnt_d   = '0;
      left_d   = '0;
      valve_d  = '0;
    end else if (!active_q) begin
      if (start && (strokes != '0)) begin
        active_d = 1'b1;
        phase_d  = '0;
        pcnt_d   = '0;
        left_d   = strokes;
        valve_d  = PHASE_TBL[0];
      end
    end else if (stroke_end) begin
      // back-to-back strokes, no gap
      left_d  = (left_q == '0) ? '0
              : left_q - STROKE_W'(1);
      phase_d = '0;
      pcnt_d  = '0;
      valve_d = PHASE_TBL[0];
    end else if (phase_end) begin
      phase_d = phase_q + 3'd1;
      pcnt_d  = '0;
      valve_d = PHASE_TBL[phase_q + 3'd1];
    end else begin
      pcnt_d = pcnt_q + PCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      pcnt_q   <= '0;
      left_q   <= '0;
      valve_q  <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      pcnt_q   <= pcnt_d;
      left_q   <= left_d;
      valve_q  <= valve_d;
    end
  end

  assign valve = valve_q;
  assign busy  = active_q && !last;

endmodule

// File: rtl/aquaflex_flow_sequencer.sv
// AquaFlex-3b flow sequencer: one command routes inlet->PumpA->Mixer1->PumpC->outlet.
// Drives switch enables/selects, pump valves, mixer; reports done/status.
module aquaflex_flow_sequencer
  import aquaflex_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int PHASE_CYC  = 2,
  parameter int MIX_W      = 16,
  parameter int STROKE_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_src,
  input  logic [1:0]          cmd_dst,
  input  logic [STROKE_W-1:0] cmd_in_strokes,
  input  logic [MIX_W-1:0]    cmd_mix_cyc,
  input  logic [STROKE_W-1:0] cmd_out_strokes,
  input  logic                abort,
  output logic                sw0_en,
  output logic                sw1_en,
  output logic                sw2_en,
  output logic [1:0]          sw0_sel,
  output logic [1:0]          sw1_sel,
  output logic [1:0]          sw2_sel,
  output logic [2:0]          pumpa_valve,
  output logic [2:0]          pumpc_valve,
  output logic                mixer_en,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status
);

  localparam int TW = MIX_W;
  localparam logic [TW-1:0] SETTLE_LD =
    TW'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [2:0]          src_q, src_d;
  logic [1:0]          dst_q, dst_d;
  logic [STROKE_W-1:0] in_q, in_d;
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic [STROKE_W-1:0] out_q, out_d;
  logic                aborted_q, aborted_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  status_e    status_q, status_d;
  logic       sw0_en_q, sw0_en_d;
  logic       sw1_en_q, sw1_en_d;
  logic       sw2_en_q, sw2_en_d;
  logic [1:0] sw0_sel_q, sw0_sel_d;
  logic [1:0] sw1_sel_q, sw1_sel_d;
  logic [1:0] sw2_sel_q, sw2_sel_d;
  logic       mixer_en_q, mixer_en_d;

  logic accept;
  logic take_abort;
  logic pa_start, pc_start;
  logic pa_busy, pc_busy;

  assign accept = cmd_valid && cmd_ready_q;
  assign take_abort = abort
    && (state_q != ST_IDLE)
    && (state_q != ST_DRAIN);

  always_comb begin
    state_d   = state_q;
    tmr_d     = (tmr_q != '0) ? tmr_q - TW'(1) : '0;
    src_d     = src_q;
    dst_d     = dst_q;
    in_d      = in_q;
    mix_d     = mix_q;
    out_d     = out_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    status_d  = STAT_OK;
    if (take_abort) begin
      state_d   = ST_DRAIN;
      tmr_d     = SETTLE_LD;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_legal(cmd_src, cmd_dst)) begin
              src_d     = cmd_src;
              dst_d     = cmd_dst;
              in_d      = cmd_in_strokes;
              mix_d     = cmd_mix_cyc;
              out_d     = cmd_out_strokes;
              aborted_d = 1'b0;
              state_d   = ST_SET_IN;
              tmr_d     = SETTLE_LD;
            end else begin
              done_d   = 1'b1;
              status_d = STAT_ILLEGAL;
            end
          end
        end
        ST_SET_IN, ST_PUMP_IN: begin
          // SET_IN ends on its timer, PUMP_IN on PumpA
          if ((state_q == ST_SET_IN)
              ? (tmr_q == '0) : !pa_busy) begin
            if (state_q == ST_SET_IN
                && in_q != '0) begin
              state_d = ST_PUMP_IN;
            end else if (mix_q != '0) begin
              state_d = ST_MIX;
              tmr_d   = mix_q - MIX_W'(1);
            end else begin
              state_d = ST_SET_OUT;
              tmr_d   = SETTLE_LD;
            end
          end
        end
        ST_MIX: begin
          if (tmr_q == '0) begin
            state_d = ST_SET_OUT;
            tmr_d   = SETTLE_LD;
          end
        end
        ST_SET_OUT: begin
          if (tmr_q == '0) begin
            if (out_q != '0) begin
              state_d = ST_PUMP_OUT;
            end else begin
              state_d = ST_DRAIN;
              tmr_d   = SETTLE_LD;
            end
          end
        end
        ST_PUMP_OUT: begin
          if (!pc_busy) begin
            state_d = ST_DRAIN;
            tmr_d   = SETTLE_LD;
          end
        end
        ST_DRAIN: begin
          if (tmr_q == '0) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            status_d = aborted_q ? STAT_ABORTED
                                 : STAT_OK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pumps load one edge early so valves move in the first pump cycle.
  assign pa_start = (state_d == ST_PUMP_IN)
                 && (state_q != ST_PUMP_IN);
  assign pc_start = (state_d == ST_PUMP_OUT)
                 && (state_q != ST_PUMP_OUT);

  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    mixer_en_d  = (state_d == ST_MIX);
    sw0_en_d    = 1'b0;
    sw1_en_d    = 1'b0;
    sw2_en_d    = 1'b0;
    sw0_sel_d   = '0;
    sw1_sel_d   = '0;
    sw2_sel_d   = '0;
    if (state_d == ST_SET_IN
        || state_d == ST_PUMP_IN) begin
      sw1_en_d = 1'b1;
      unique case (1'b1)
        (src_d == SRC_B): sw1_sel_d = SW1_PORT_B;
        (src_d == SRC_F): sw1_sel_d = SW1_PORT_F;
        (src_d == SRC_C): begin
          sw1_sel_d = SW1_PORT_SW0;
          sw0_en_d  = 1'b1;
          sw0_sel_d = SW0_PORT_C;
        end
        (src_d == SRC_D): begin
          sw1_sel_d = SW1_PORT_SW0;
          sw0_en_d  = 1'b1;
          sw0_sel_d = SW0_PORT_D;
        end
        (src_d == SRC_E): begin
          sw1_sel_d = SW1_PORT_SW0;
          sw0_en_d  = 1'b1;
          sw0_sel_d = SW0_PORT_E;
        end
        default: sw1_en_d = 1'b0;
      endcase
    end
    if (state_d == ST_SET_OUT
        || state_d == ST_PUMP_OUT) begin
      sw2_en_d = 1'b1;
      unique case (1'b1)
        (dst_d == DST_H): sw2_sel_d = SW2_PORT_H;
        (dst_d == DST_I): sw2_sel_d = SW2_PORT_I;
        (dst_d == DST_J): sw2_sel_d = SW2_PORT_J;
        default: sw2_en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      in_q        <= '0;
      mix_q       <= '0;
      out_q       <= '0;
      aborted_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= STAT_OK;
      sw0_en_q    <= 1'b0;
      sw1_en_q    <= 1'b0;
      sw2_en_q    <= 1'b0;
      sw0_sel_q   <= '0;
      sw1_sel_q   <= '0;
      sw2_sel_q   <= '0;
      mixer_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      in_q        <= in_d;
      mix_q       <= mix_d;
      out_q       <= out_d;
      aborted_q   <= aborted_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
      sw0_en_q    <= sw0_en_d;
      sw1_en_q    <= sw1_en_d;
      sw2_en_q    <= sw2_en_d;
      sw0_sel_q   <= sw0_sel_d;
      sw1_sel_q   <= sw1_sel_d;
      sw2_sel_q   <= sw2_sel_d;
      mixer_en_q  <= mixer_en_d;
    end
  end

  peristaltic_pump_drv #(
    .PHASE_CYC (PHASE_CYC),
    .STROKE_W  (STROKE_W)
  ) u_pumpa (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (pa_start),
    .strokes (in_q),
    .stop    (take_abort),
    .valve   (pumpa_valve),
    .busy    (pa_busy)
  );

  peristaltic_pump_drv #(
    .PHASE_CYC (PHASE_CYC),
    .STROKE_W  (STROKE_W)
  ) u_pumpc (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (pc_start),
    .strokes (out_q),
    .stop    (take_abort),
    .valve   (pumpc_valve),
    .busy    (pc_busy)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign sw0_en    = sw0_en_q;
  assign sw1_en    = sw1_en_q;
  assign sw2_en    = sw2_en_q;
  assign sw0_sel   = sw0_sel_q;
  assign sw1_sel   = sw1_sel_q;
  assign sw2_sel   = sw2_sel_q;
  assign mixer_en  = mixer_en_q;

endmodule

// File: tb/tb_aquaflex_flow_sequencer.sv
// Bench for aquaflex_flow_sequencer: per-cycle schedule model
// plus directed literal checks and randomized commands.
module tb_aquaflex_flow_sequencer;

  localparam int SETTLE = 4;
  localparam int PHASE  = 2;
  localparam int K_IDLE  = 0;
  localparam int K_RUN   = 1;
  localparam int K_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_src = '0;
  logic [1:0]  cmd_dst = '0;
  logic [7:0]  cmd_in_strokes = '0;
  logic [15:0] cmd_mix_cyc = '0;
  logic [7:0]  cmd_out_strokes = '0;
  logic        abort = 1'b0;
  logic        sw0_en, sw1_en, sw2_en;
  logic [1:0]  sw0_sel, sw1_sel, sw2_sel;
  logic [2:0]  pumpa_valve, pumpc_valve;
  logic        mixer_en, busy, done;
  logic [1:0]  status;

  aquaflex_flow_sequencer #(
    .SETTLE_CYC (SETTLE),
    .PHASE_CYC  (PHASE),
    .MIX_W      (16),
    .STROKE_W   (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_src         (cmd_src),
    .cmd_dst         (cmd_dst),
    .cmd_in_strokes  (cmd_in_strokes),
    .cmd_mix_cyc     (cmd_mix_cyc),
    .cmd_out_strokes (cmd_out_strokes),
    .abort           (abort),
    .sw0_en          (sw0_en),
    .sw1_en          (sw1_en),
    .sw2_en          (sw2_en),
    .sw0_sel         (sw0_sel),
    .sw1_sel         (sw1_sel),
    .sw2_sel         (sw2_sel),
    .pumpa_valve     (pumpa_valve),
    .pumpc_valve     (pumpc_valve),
    .mixer_en        (mixer_en),
    .busy            (busy),
    .done            (done),
    .status          (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic       sw0_en;
    logic [1:0] sw0_sel;
    logic       sw1_en;
    logic [1:0] sw1_sel;
    logic       sw2_en;
    logic [1:0] sw2_sel;
    logic [2:0] pa;
    logic [2:0] pc;
    logic       mixer;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic [1:0] kind;
  } ent_t;

  logic [2:0] vtab [6] = '{3'b100, 3'b110, 3'b010,
                           3'b011, 3'b001, 3'b101};

  ent_t q[$];
  ent_t cur;

  function automatic ent_t idle_ent();
    ent_t e;
    e = '0;
    e.o.cmd_ready = 1'b1;
    return e;
  endfunction

  function automatic ent_t mk(int kind);
    ent_t e;
    e = '0;
    e.kind = 2'(kind);
    e.o.busy = 1'b1;
    return e;
  endfunction

  function automatic ent_t done_ent(logic [1:0] st);
    ent_t e;
    e = idle_ent();
    e.o.done = 1'b1;
    e.o.status = st;
    return e;
  endfunction

  function automatic ent_t route_in(ent_t e, logic [2:0] s);
    e.o.sw1_en = 1'b1;
    case (s)
      3'd0: e.o.sw1_sel = 2'd3;
      3'd4: e.o.sw1_sel = 2'd0;
      3'd1: begin e.o.sw1_sel = 2'd1; e.o.sw0_en = 1'b1; e.o.sw0_sel = 2'd2; end
      3'd2: begin e.o.sw1_sel = 2'd1; e.o.sw0_en = 1'b1; e.o.sw0_sel = 2'd0; end
      default: begin e.o.sw1_sel = 2'd1; e.o.sw0_en = 1'b1; e.o.sw0_sel = 2'd3; end
    endcase
    return e;
  endfunction

  task automatic push_n(ent_t e, int n);
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Full expected output timeline of one legal command.
  task automatic plan(logic [2:0] s, logic [1:0] d,
                      int ni, int nm, int no);
    ent_t e;
    ent_t p;
    e = route_in(mk(K_RUN), s);
    push_n(e, SETTLE);
    for (int k = 0; k < ni; k++)
      for (int ph = 0; ph < 6; ph++) begin
        p = e; p.o.pa = vtab[ph]; push_n(p, PHASE);
      end
    e = mk(K_RUN); e.o.mixer = 1'b1;
    push_n(e, nm);
    e = mk(K_RUN); e.o.sw2_en = 1'b1;
    e.o.sw2_sel = (d == 2'd0) ? 2'd2 : (d == 2'd1) ? 2'd3 : 2'd1;
    push_n(e, SETTLE);
    for (int k = 0; k < no; k++)
      for (int ph = 0; ph < 6; ph++) begin
        p = e; p.o.pc = vtab[ph]; push_n(p, PHASE);
      end
    push_n(mk(K_DRAIN), SETTLE);
    q.push_back(done_ent(2'd0));
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      cur = idle_ent();
    end else begin
      if (cur.kind == 2'(K_RUN) && abort) begin
        q.delete();
        push_n(mk(K_DRAIN), SETTLE);
        q.push_back(done_ent(2'd2));
      end else if (cur.o.cmd_ready && cmd_valid) begin
        q.delete();
        if (cmd_src > 3'd4 || cmd_dst > 2'd2)
          q.push_back(done_ent(2'd1));
        else
          plan(cmd_src, cmd_dst, int'(cmd_in_strokes),
               int'(cmd_mix_cyc), int'(cmd_out_strokes));
      end
      cur = (q.size() != 0) ? q.pop_front() : idle_ent();
    end
  end

  obs_t got_o, exp_o;
  always begin
    @(negedge clk);
    got_o = {cmd_ready, busy, done, status, sw0_en, sw0_sel,
             sw1_en, sw1_sel, sw2_en, sw2_sel,
             pumpa_valve, pumpc_valve, mixer_en};
    exp_o = rst_n ? cur.o : idle_ent().o;
    checks++;
    if (got_o !== exp_o) begin
      failures++;
      $display("FAIL model cyc=%0d got=%b exp=%b",
               cyc, got_o, exp_o);
    end
  end

  task automatic chk(string nm, logic [31:0] g, logic [31:0] x);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, x);
    end
  endtask

  task automatic wait_cyc(int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  int t0;
  task automatic send(logic [2:0] s, logic [1:0] d,
                      int ni, int nm, int no);
    @(posedge clk); #1;
    cmd_src = s; cmd_dst = d;
    cmd_in_strokes = 8'(ni);
    cmd_mix_cyc = 16'(nm);
    cmd_out_strokes = 8'(no);
    cmd_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  int seen, bad, n, early, ovl, T;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    wait_cyc(cyc + 2);

    // Scenario 1: C -> I
    send(3'd1, 2'd1, 1, 10, 2); T = t0;
    wait_cyc(T + 1);
    chk("s1_sw0_sel", sw0_sel, 2);
    chk("s1_sw1_sel", sw1_sel, 1);
    chk("s1_sw0_en", sw0_en, 1);
    wait_cyc(T + 16); chk("s1_mix_pre", mixer_en, 0);
    wait_cyc(T + 17); chk("s1_mix_first", mixer_en, 1);
    wait_cyc(T + 26); chk("s1_mix_last", mixer_en, 1);
    wait_cyc(T + 27);
    chk("s1_mix_off", mixer_en, 0);
    chk("s1_sw2_sel", sw2_sel, 3);
    wait_cyc(T + 30); chk("s1_pc_pre", pumpc_valve, 0);
    wait_cyc(T + 31); chk("s1_pc_first", pumpc_valve, 3'b100);
    wait_cyc(T + 58); chk("s1_done_pre", done, 0);
    wait_cyc(T + 59);
    chk("s1_done", done, 1);
    chk("s1_status", status, 0);
    chk("s1_ready", cmd_ready, 1);
    wait_cyc(T + 60); chk("s1_done_pulse", done, 0);

    // Scenario 2: B -> J, no pump-in, no mix
    send(3'd0, 2'd2, 0, 0, 1); T = t0;
    bad = 0;
    for (int c = 1; c <= 25; c++) begin
      wait_cyc(T + c);
      if (sw0_en) bad++;
      if (c == 5) chk("s2_sw2_sel", sw2_sel, 1);
      if (c == 9) chk("s2_pc_first", pumpc_valve, 3'b100);
      if (c == 20) chk("s2_pc_last", pumpc_valve, 3'b101);
      if (c == 21) chk("s2_drain_valve", pumpc_valve, 0);
      if (c == 24) chk("s2_done_pre", done, 0);
    end
    chk("s2_done", done, 1);
    chk("s2_status", status, 0);
    chk("s2_sw0_never", bad, 0);

    // Illegal src and dst
    send(3'd5, 2'd0, 1, 1, 1); T = t0;
    wait_cyc(T + 1);
    chk("il_done", done, 1);
    chk("il_status", status, 1);
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      wait_cyc(T + c);
      if (busy || pumpa_valve != 0 || pumpc_valve != 0) bad++;
    end
    chk("il_quiet", bad, 0);
    send(3'd2, 2'd3, 1, 1, 1); T = t0;
    wait_cyc(T + 1);
    chk("il2_status", status, 1);
    chk("il2_busy", busy, 0);

    // Abort during MIX
    send(3'd1, 2'd1, 1, 10, 2); T = t0;
    wait_cyc(T + 20);
    chk("ab_mix_on", mixer_en, 1);
    abort = 1'b1;
    wait_cyc(T + 21);
    abort = 1'b0;
    chk("ab_mix_off", mixer_en, 0);
    chk("ab_busy", busy, 1);
    wait_cyc(T + 24); chk("ab_done_pre", done, 0);
    wait_cyc(T + 25);
    chk("ab_done", done, 1);
    chk("ab_status", status, 2);

    // Reset mid-operation
    send(3'd1, 2'd1, 1, 10, 2); T = t0;
    wait_cyc(T + 10);
    chk("rs_pumping", pumpa_valve != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_ready", cmd_ready, 1);
    chk("rs_busy", busy, 0);
    chk("rs_pa", pumpa_valve, 0);
    chk("rs_sw1", sw1_en, 0);
    wait_cyc(T + 12);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int c = 13; c <= 70; c++) begin
      wait_cyc(T + c);
      if (done || busy) bad++;
    end
    chk("rs_no_done", bad, 0);

    // Two queued commands, valid held high
    @(posedge clk); #1;
    cmd_src = 3'd2; cmd_dst = 2'd0; cmd_in_strokes = 8'd1;
    cmd_mix_cyc = 16'd3; cmd_out_strokes = 8'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_src = 3'd4; cmd_dst = 2'd2; cmd_in_strokes = 8'd2;
    cmd_mix_cyc = 16'd0; cmd_out_strokes = 8'd1;
    n = 0; early = 0; ovl = 0; seen = 0;
    while (seen == 0 && n < 300) begin
      @(negedge clk); n++;
      if (pumpa_valve != 0 && pumpc_valve != 0) ovl++;
      if (done) seen = 1;
      else if (cmd_ready) early++;
    end
    chk("q_done_seen", seen, 1);
    chk("q_ready_early", early, 0);
    chk("q_ready_at_done", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("q_second_busy", busy, 1);
    chk("q_second_sw1", sw1_sel, 0);
    n = 0; seen = 0;
    while (seen == 0 && n < 300) begin
      @(negedge clk); n++;
      if (pumpa_valve != 0 && pumpc_valve != 0) ovl++;
      if (done) seen = 1;
    end
    chk("q_second_done", seen, 1);
    chk("q_overlap", ovl, 0);

    // Randomized commands with random abort and reset
    for (int it = 0; it < 30; it++) begin
      @(posedge clk); #1;
      cmd_src = 3'($urandom_range(0, 5));
      cmd_dst = ($urandom_range(0, 7) == 0) ? 2'd3
              : 2'($urandom_range(0, 2));
      cmd_in_strokes = 8'($urandom_range(0, 3));
      cmd_mix_cyc = 16'($urandom_range(0, 12));
      cmd_out_strokes = 8'($urandom_range(0, 3));
      cmd_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!cmd_ready && n < 500);
      chk("rnd_accept_timeout", n < 500, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = $urandom_range(0, 60);
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        abort = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      abort = 1'b0;
      if (it % 9 == 4) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    repeat (120) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
